// File: rtl/wave_sample_gen.sv
// Sample source for a DAC7611 serializer: one sample slot every SAMPLE_DIV clocks,
// five selectable waveforms, valid/ready hand-off and a saturating overrun counter.
module wave_sample_gen #(
   parameter int SAMPLE_DIV = 300,
   parameter int SQ_HALF    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [2:0]  wave_sel,
   input  logic [11:0] amp,
   input  logic [11:0] step,
   input  logic        sample_ready,
   output logic [11:0] sample,
   output logic        sample_valid,
   output logic [2:0]  wave_active,
   output logic [7:0]  overrun_cnt
);

   localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int HALF_W = (SQ_HALF > 1) ? $clog2(SQ_HALF) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SQ_HALF - 1);

   localparam logic [2:0] WAVE_DC     = 3'd0;
   localparam logic [2:0] WAVE_SQUARE = 3'd1;
   localparam logic [2:0] WAVE_SAW    = 3'd2;
   localparam logic [2:0] WAVE_TRI    = 3'd3;
   localparam logic [2:0] WAVE_STAIR  = 3'd4;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   // slot divider
   logic [DIV_W-1:0]  div_cnt_reg;
   logic [DIV_W-1:0]  div_cnt_next;
   logic              tick;
   logic              load;
   logic              overrun;

   // waveform state
   logic [12:0]       acc_reg;
   dir_t              dir_reg;
   logic [HALF_W-1:0] half_reg;
   logic              phase_low_reg;
   logic [2:0]        stair_idx_reg;

   // state after the optional clear on a waveform change
   logic              sel_change;
   logic [12:0]       acc_cur;
   dir_t              dir_cur;
   logic [HALF_W-1:0] half_cur;
   logic              low_cur;
   logic [2:0]        idx_cur;

   // state and sample produced by a loading tick
   logic [12:0]       acc_next;
   dir_t              dir_next;
   logic [HALF_W-1:0] half_next;
   logic              phase_low_next;
   logic [2:0]        stair_idx_next;
   logic [11:0]       sample_next;

   // arithmetic helpers
   logic [12:0]       amp_ext;
   logic [12:0]       step_ext;
   logic [13:0]       acc_sum;
   logic              sum_over_amp;
   logic [11:0]       acc_clip;
   logic [12:0]       tri_up;
   logic [11:0]       stair_val;

   always_comb begin
      div_cnt_next = '0;
      if (enable && (div_cnt_reg != DIV_LAST)) begin
         div_cnt_next = div_cnt_reg + 1'b1;
      end
   end

   assign tick    = enable && (div_cnt_reg == DIV_LAST);
   assign load    = tick && (!sample_valid || sample_ready);
   assign overrun = tick && sample_valid && !sample_ready;

   assign sel_change = (wave_sel != wave_active);
   assign acc_cur    = sel_change ? 13'd0 : acc_reg;
   assign dir_cur    = sel_change ? DIR_UP : dir_reg;
   assign half_cur   = sel_change ? '0 : half_reg;
   assign low_cur    = sel_change ? 1'b0 : phase_low_reg;
   assign idx_cur    = sel_change ? 3'd0 : stair_idx_reg;

   // acc never exceeds 4095, so the 14-bit sum cannot wrap
   assign amp_ext      = {1'b0, amp};
   assign step_ext     = {1'b0, step};
   assign acc_sum      = {1'b0, acc_cur} + {1'b0, step_ext};
   assign sum_over_amp = (acc_sum > {1'b0, amp_ext});
   assign acc_clip     = (acc_cur > amp_ext) ? amp : acc_cur[11:0];
   assign tri_up       = sum_over_amp ? amp_ext : acc_sum[12:0];
   assign stair_val    = {3'd0, amp[11:3]} * {9'd0, idx_cur};

   always_comb begin
      sample_next    = '0;
      acc_next       = acc_cur;
      dir_next       = dir_cur;
      half_next      = half_cur;
      phase_low_next = low_cur;
      stair_idx_next = idx_cur;
      case (wave_sel)
         WAVE_DC: begin
            sample_next = amp;
         end
         WAVE_SQUARE: begin
            sample_next = low_cur ? 12'd0 : amp;
            if (half_cur == HALF_LAST) begin
               half_next      = '0;
               phase_low_next = !low_cur;
            end else begin
               half_next = half_cur + 1'b1;
            end
         end
         WAVE_SAW: begin
            sample_next = acc_clip;
            acc_next    = sum_over_amp ? 13'd0 : acc_sum[12:0];
         end
         WAVE_TRI: begin
            sample_next = acc_clip;
            if (dir_cur == DIR_UP) begin
               acc_next = tri_up;
               if (tri_up == amp_ext) begin
                  dir_next = DIR_DOWN;
               end
            end else if (acc_cur <= step_ext) begin
               acc_next = 13'd0;
               dir_next = DIR_UP;
            end else begin
               acc_next = acc_cur - step_ext;
            end
         end
         WAVE_STAIR: begin
            sample_next    = stair_val;
            stair_idx_next = idx_cur + 3'd1;
         end
         default: begin
            sample_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_reg <= '0;
      end else begin
         div_cnt_reg <= div_cnt_next;
      end
   end

   // a stalled slot leaves sample and waveform state untouched
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sample        <= '0;
         sample_valid  <= 1'b0;
         wave_active   <= '0;
         acc_reg       <= '0;
         dir_reg       <= DIR_UP;
         half_reg      <= '0;
         phase_low_reg <= 1'b0;
         stair_idx_reg <= '0;
      end else if (load) begin
         sample        <= sample_next;
         sample_valid  <= 1'b1;
         wave_active   <= wave_sel;
         acc_reg       <= acc_next;
         dir_reg       <= dir_next;
         half_reg      <= half_next;
         phase_low_reg <= phase_low_next;
         stair_idx_reg <= stair_idx_next;
      end else if (sample_valid && sample_ready) begin
         sample_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun_cnt <= '0;
      end else if (overrun && (overrun_cnt != 8'hFF)) begin
         overrun_cnt <= overrun_cnt + 8'd1;
      end
   end

endmodule

// File: doc/wave_sample_gen.md
WAVE_SAMPLE_GEN -- requirements
Module: wave_sample_gen

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 300, clk cycles per sample slot (one DAC7611 frame).
REQ-002 SHALL have parameter SQ_HALF, default 16, square-wave half-period in samples.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  allows new sample slots when high.
REQ-006 SHALL have port wave_sel  input  3  0 DC, 1 square, 2 sawtooth, 3 triangle, 4 staircase, 5-7 zero.
REQ-007 SHALL have port amp  input  12  peak code (unsigned DAC code).
REQ-008 SHALL have port step  input  12  per-sample increment for sawtooth/triangle.
REQ-009 SHALL have port sample_ready  input  1  downstream serializer accepts sample.
REQ-010 SHALL have port sample  output  12  DAC code to serialize.
REQ-011 SHALL have port sample_valid  output  1  sample holds a code not yet accepted.
REQ-012 SHALL have port wave_active  output  3  waveform currently generated.
REQ-013 SHALL have port overrun_cnt  output  8  saturating count of dropped slots.

Function
REQ-014 SHALL run divider div_cnt 0..SAMPLE_DIV-1 while enable=1, wrapping to 0; tick = enable and div_cnt==SAMPLE_DIV-1; enable=0 holds div_cnt at 0.
REQ-015 SHALL, on tick with sample_valid=0 or sample_ready=1, load sample and assert sample_valid in the next cycle (latency 1 clk), then advance waveform state.
REQ-016 SHALL, on tick with sample_valid=1 and sample_ready=0, keep sample unchanged, not advance waveform state, and increment overrun_cnt saturating at 255.
REQ-017 SHALL deassert sample_valid the cycle after sample_valid and sample_ready both high, unless REQ-015 reloads in that same cycle (valid then stays high with new code).
REQ-018 SHALL hold sample stable while sample_valid=1 and sample_ready=0.
REQ-019 SHALL latch wave_sel into wave_active only at a loading tick; on change, clear all waveform state before computing the loaded sample.
REQ-020 SHALL sample amp and step at each loading tick; mid-wave changes apply from that sample.
REQ-021 DC: sample = amp every slot.
REQ-022 Square: half counter 0..SQ_HALF-1; sample = amp in high phase, 0 in low phase; first SQ_HALF samples after reset/change are high.
REQ-023 Sawtooth: 13-bit accumulator acc; sample = min(acc, amp); next acc = 0 if acc+step > amp, else acc+step; step=0 yields constant 0.
REQ-024 Triangle: acc plus direction bit (up after reset); up: next = min(acc+step, amp), flip down when next==amp; down: next = acc-step clamped at 0, flip up when next==0; sample = min(acc, amp).
REQ-025 Staircase: index 0..7 wrapping; sample = (amp>>3)*index, 12-bit result.
REQ-026 wave_active 5-7: sample = 0.
REQ-027 All arithmetic unsigned; no wrap of 12-bit output beyond amp.
REQ-028 enable=0 SHALL not cancel a pending sample_valid; handshake completes normally.

Reset
REQ-029 SHALL, on reset, asynchronously set div_cnt=0, sample=0, sample_valid=0, wave_active=0, overrun_cnt=0, acc=0, direction=up, half counter=0, square phase=high, stair index=0.
REQ-030 SHALL, on reset mid-handshake, drop the pending sample; first sample after release appears SAMPLE_DIV+1 clks after first enabled cycle.

Verification
REQ-031 SAMPLE_DIV=4, sel=2, amp=10, step=4, ready=1 -> samples 0,4,8,0,4 one per 4 clks, valid pulses 1 clk.
REQ-032 sel=3, amp=10, step=4, ready=1 -> 0,4,8,10,6,2,0,4.
REQ-033 sel=1, SQ_HALF=2, amp=4095 -> 4095,4095,0,0,4095.
REQ-034 sel=4, amp=800 -> 0,100,200,...,700,0.
REQ-035 ready=0 for 3 slots with valid held -> sample frozen, overrun_cnt=3; ready=1 -> transfer, sequence resumes without skip.
REQ-036 sel changed 2->0 mid-period, reset asserted mid-valid -> wave_active updates only at tick; reset forces all outputs 0 immediately.
